// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the convolution sequencing controller.
// Optional build macro CONV_RELU_EN (handled in conv_sched) clamps negative
// results to zero on the output stream.
package Conv;

    localparam int DATA_W = 8;
    localparam int LEN    = 5;
    localparam int ACC_W  = 2 * DATA_W + $clog2(LEN);
    localparam int TAP_W  = (LEN > 1) ? $clog2(LEN) : 1;

    typedef logic signed [DATA_W-1:0] data_t;
    // Index 0 holds the oldest sample of the window.
    typedef data_t [LEN-1:0] data_vector;
    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        KLOAD    = 3'd1,
        WAIT_WIN = 3'd2,
        MAC      = 3'd3,
        EMIT     = 3'd4,
        DONE     = 3'd5
    } sched_state_t;

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate: one full-precision product per enabled cycle.
// clr has priority over en and zeroes the accumulator.
module conv_mac
    import Conv::*;
#(
    parameter int ACC_W = Conv::ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  data_t                   a,
    input  data_t                   b,
    output logic signed [ACC_W-1:0] acc
);

    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  acc_r;

    // Operands are sign-extended before the multiply so the product is exact.
    assign prod_s = PROD_W'(a) * PROD_W'(b);
    assign acc    = acc_r;

    // Accumulator register: clear, accumulate or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (clr) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (en) begin
            acc_r <= acc_r + ACC_W'(prod_s);
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/conv_sched.sv
// Convolution sequencing controller: loads a LEN-tap kernel, drops the
// LEN-1 warm-up windows of a frame, computes one dot product per remaining
// window (one tap per cycle) and streams the results out.
// Build macro CONV_RELU_EN: when defined, negative results are presented as 0.
module conv_sched
    import Conv::*;
#(
    parameter int ACC_W   = 2 * Conv::DATA_W + $clog2(Conv::LEN),
    parameter int FRAME_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [FRAME_W-1:0]      frame_len,
    output logic                    busy,
    output logic                    done,
    input  data_t                   k_data,
    input  logic                    k_valid,
    output logic                    k_ready,
    input  data_vector              win_data,
    input  logic                    win_valid,
    output logic                    win_ready,
    output logic signed [ACC_W-1:0] res_data,
    output logic                    res_valid,
    input  logic                    res_ready
);

    sched_state_t            state_r;
    sched_state_t            state_next_s;
    logic [FRAME_W-1:0]      frame_len_r;
    logic [FRAME_W-1:0]      win_cnt_r;
    logic [FRAME_W-1:0]      win_cnt_inc_s;
    logic [TAP_W-1:0]        k_idx_r;
    logic [TAP_W-1:0]        tap_r;
    data_t                   k_r [LEN];
    data_vector              win_r;
    logic                    k_we_s;
    logic                    win_we_s;
    logic                    mac_clr_s;
    logic                    mac_en_s;
    logic                    busy_r;
    logic                    done_r;
    logic                    k_ready_r;
    logic                    win_ready_r;
    logic                    res_valid_r;
    logic signed [ACC_W-1:0] acc_s;

    assign win_cnt_inc_s = win_cnt_r + FRAME_W'(1);

    conv_mac #(.ACC_W(ACC_W)) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr_s),
        .en  (mac_en_s),
        .a   (win_r[tap_r]),
        .b   (k_r[tap_r]),
        .acc (acc_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_next_s = state_r;
        k_we_s       = 1'b0;
        win_we_s     = 1'b0;
        mac_clr_s    = 1'b0;
        mac_en_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = KLOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            KLOAD: begin
                if (k_valid) begin
                    k_we_s = 1'b1;
                    if (k_idx_r == TAP_W'(LEN - 1)) begin
                        if (frame_len_r == {FRAME_W{1'b0}}) begin
                            state_next_s = DONE;
                        end else begin
                            state_next_s = WAIT_WIN;
                        end
                    end else begin
                        state_next_s = KLOAD;
                    end
                end else begin
                    state_next_s = KLOAD;
                end
            end
            WAIT_WIN: begin
                if (win_valid) begin
                    win_we_s = 1'b1;
                    if (win_cnt_inc_s < FRAME_W'(LEN)) begin
                        // Warm-up window: not yet a full kernel's worth of history.
                        if (win_cnt_inc_s == frame_len_r) begin
                            state_next_s = DONE;
                        end else begin
                            state_next_s = WAIT_WIN;
                        end
                    end else begin
                        mac_clr_s    = 1'b1;
                        state_next_s = MAC;
                    end
                end else begin
                    state_next_s = WAIT_WIN;
                end
            end
            MAC: begin
                mac_en_s = 1'b1;
                if (tap_r == TAP_W'(LEN - 1)) begin
                    state_next_s = EMIT;
                end else begin
                    state_next_s = MAC;
                end
            end
            EMIT: begin
                if (res_ready) begin
                    if (win_cnt_r == frame_len_r) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = WAIT_WIN;
                    end
                end else begin
                    state_next_s = EMIT;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Frame bookkeeping, kernel store, window latch and tap counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_len_r <= {FRAME_W{1'b0}};
            win_cnt_r   <= {FRAME_W{1'b0}};
            k_idx_r     <= {TAP_W{1'b0}};
            tap_r       <= {TAP_W{1'b0}};
            win_r       <= {(LEN * DATA_W){1'b0}};
            for (int i = 0; i < LEN; i++) begin
                k_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if ((state_r == IDLE) && start) begin
                frame_len_r <= frame_len;
                win_cnt_r   <= {FRAME_W{1'b0}};
                k_idx_r     <= {TAP_W{1'b0}};
            end
            if (k_we_s) begin
                k_r[k_idx_r] <= k_data;
                if (k_idx_r == TAP_W'(LEN - 1)) begin
                    k_idx_r <= {TAP_W{1'b0}};
                end else begin
                    k_idx_r <= k_idx_r + TAP_W'(1);
                end
            end
            if (win_we_s) begin
                win_r     <= win_data;
                win_cnt_r <= win_cnt_inc_s;
            end
            if (mac_clr_s) begin
                tap_r <= {TAP_W{1'b0}};
            end else if (mac_en_s) begin
                tap_r <= tap_r + TAP_W'(1);
            end
        end
    end

    // Handshake/status outputs registered from the upcoming state so they
    // line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            k_ready_r   <= 1'b0;
            win_ready_r <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            busy_r      <= (state_next_s != IDLE);
            done_r      <= (state_next_s == DONE);
            k_ready_r   <= (state_next_s == KLOAD);
            win_ready_r <= (state_next_s == WAIT_WIN);
            res_valid_r <= (state_next_s == EMIT);
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign k_ready   = k_ready_r;
    assign win_ready = win_ready_r;
    assign res_valid = res_valid_r;

    // The accumulator holds still through EMIT, so it drives the result
    // directly; its reset value gives res_data=0.
`ifdef CONV_RELU_EN
    assign res_data = acc_s[ACC_W-1] ? {ACC_W{1'b0}} : acc_s;
`else
    assign res_data = acc_s;
`endif

endmodule
